// File: rtl/jogo_memoria_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jogo_memoria_pkg                                             |
// | Description : Shared state codes, LFSR taps and bit helpers for the        |
// |               sequence-memory game core.                                   |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
package jogo_memoria_pkg;

  // State codes are visible on db_estado, so every value is pinned explicitly.
  typedef enum logic [4:0] {
    INICIAL     = 5'h00,
    PREPARA     = 5'h01,
    MOSTRA      = 5'h02,
    INTERVALO   = 5'h03,
    ESPERA      = 5'h04,
    COMPARA     = 5'h05,
    PROX_JOGADA = 5'h06,
    PROX_RODADA = 5'h07,
    ESCREVE     = 5'h08,
    ESPERA_ESC  = 5'h09,
    FIM_GANHOU  = 5'h0A,
    FIM_PERDEU  = 5'h0B,
    FIM_TIMEOUT = 5'h0C
  } estado_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10.
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  // Number of set bits; used to reject multi-button presses.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Index to one-hot; callers truncate to their button count.
  function automatic logic [31:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

  // Lowest set bit position of a press vector.
  function automatic logic [4:0] indice(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) r = 5'(i);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jogo_memoria_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jogo_memoria_lfsr                                            |
// | Description : Free-running 16-bit Fibonacci LFSR that feeds the random     |
// |               sequence; restarts from SEMENTE on reset.                    |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module jogo_memoria_lfsr
  import jogo_memoria_pkg::*;
#(
  parameter logic [15:0] SEMENTE = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = ^(r_lfsr & c_LFSR_TAPS);

  // Shift every clock so the moment the player presses jogar picks the sequence.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_lfsr <= SEMENTE;
    else        r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/jogo_memoria_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jogo_memoria_param                                           |
// | Description : Parametrised Simon-style game core: plays back a growing     |
// |               sequence, checks presses, flags win / loss / timeout, and    |
// |               supports a player-written (desafio) sequence mode.           |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int          N_BOTOES       = 4,
  parameter int          PROFUNDIDADE   = 16,
  parameter int          LED_CICLOS     = 1000,
  parameter int          TIMEOUT_CICLOS = 5000,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            jogar,
  input  logic [1:0]                      configuracao,
  input  logic [N_BOTOES-1:0]             botoes,
  output logic [N_BOTOES-1:0]             leds,
  output logic                            pronto,
  output logic                            ganhou,
  output logic                            perdeu,
  output logic                            timeout,
  output logic [4:0]                      db_estado,
  output logic [$clog2(PROFUNDIDADE)-1:0] db_rodada
);

  localparam int c_IDX_W   = $clog2(N_BOTOES);
  localparam int c_ADDR_W  = $clog2(PROFUNDIDADE);
  localparam int c_TMR_MAX = (TIMEOUT_CICLOS > LED_CICLOS) ? TIMEOUT_CICLOS : LED_CICLOS;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0]  c_LED_FIM   = c_TMR_W'(LED_CICLOS - 1);
  localparam logic [c_TMR_W-1:0]  c_GAP_FIM   = c_TMR_W'(LED_CICLOS / 2 - 1);
  localparam logic [c_TMR_W-1:0]  c_TO_FIM    = c_TMR_W'(TIMEOUT_CICLOS - 1);
  localparam logic [c_ADDR_W-1:0] c_PROF_FIM  = c_ADDR_W'(PROFUNDIDADE - 1);
  localparam logic [c_ADDR_W-1:0] c_CURTO_FIM = c_ADDR_W'(PROFUNDIDADE / 4 - 1);

  estado_t              r_estado, w_prox;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_ADDR_W-1:0]  r_addr, r_rodada, r_limite;
  logic                 r_desafio;
  logic [N_BOTOES-1:0]  r_botoes, r_botoes_ant, r_press;
  logic [c_IDX_W-1:0]   r_mem [PROFUNDIDADE];

  logic [15:0]          w_lfsr;
  logic [c_IDX_W-1:0]   w_lfsr_idx, w_idx_press, w_mem_wdata;
  logic [c_ADDR_W-1:0]  w_mem_waddr;
  logic [N_BOTOES-1:0]  w_led_mem;
  logic                 w_jogada, w_multi_press, w_multi_botoes;
  logic                 w_timer_inc, w_timer_clr, w_addr_inc, w_addr_clr;
  logic                 w_rodada_inc, w_iniciar, w_captura, w_mem_we;

  jogo_memoria_lfsr #(.SEMENTE(SEMENTE)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .lfsr  (w_lfsr)
  );

  assign w_lfsr_idx     = c_IDX_W'(w_lfsr % 16'(N_BOTOES));
  assign w_jogada       = (r_botoes != '0) && (r_botoes_ant == '0);
  assign w_multi_press  = popcount(32'(r_press)) > 32'd1;
  assign w_multi_botoes = popcount(32'(r_botoes)) > 32'd1;
  assign w_idx_press    = c_IDX_W'(indice(32'(r_press)));
  assign w_led_mem      = N_BOTOES'(onehot(5'(r_mem[r_addr])));

  // Single register stage on the buttons plus a history copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_botoes     <= '0;
      r_botoes_ant <= '0;
    end else begin
      r_botoes     <= botoes;
      r_botoes_ant <= r_botoes;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_prox;
  end

  // Next-state, datapath strobes and led drive.
  always_comb begin
    w_prox       = r_estado;
    w_timer_inc  = 1'b0;
    w_timer_clr  = 1'b0;
    w_addr_inc   = 1'b0;
    w_addr_clr   = 1'b0;
    w_rodada_inc = 1'b0;
    w_iniciar    = 1'b0;
    w_captura    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = r_addr;
    w_mem_wdata  = w_lfsr_idx;
    leds         = '0;
    case (r_estado)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (jogar) begin
          w_prox    = PREPARA;
          w_iniciar = 1'b1;
        end
      end
      PREPARA: begin
        // Desafio seeds only the first entry; the player writes the rest.
        w_mem_we = 1'b1;
        if (r_desafio || (r_addr == c_PROF_FIM)) begin
          w_prox      = MOSTRA;
          w_addr_clr  = 1'b1;
          w_timer_clr = 1'b1;
        end else begin
          w_addr_inc = 1'b1;
        end
      end
      MOSTRA: begin
        leds = w_led_mem;
        if (r_timer == c_LED_FIM) begin
          w_prox      = INTERVALO;
          w_timer_clr = 1'b1;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      INTERVALO: begin
        if (r_timer == c_GAP_FIM) begin
          w_timer_clr = 1'b1;
          if (r_addr == r_rodada) begin
            w_prox     = ESPERA;
            w_addr_clr = 1'b1;
          end else begin
            w_prox     = MOSTRA;
            w_addr_inc = 1'b1;
          end
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ESPERA: begin
        leds = r_botoes;
        // A press landing on the expiry clock still counts.
        if (w_jogada) begin
          w_prox    = COMPARA;
          w_captura = 1'b1;
        end else if (r_timer == c_TO_FIM) begin
          w_prox = FIM_TIMEOUT;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      COMPARA: begin
        if (w_multi_press || (w_idx_press != r_mem[r_addr])) w_prox = FIM_PERDEU;
        else if (r_addr != r_rodada)                          w_prox = PROX_JOGADA;
        else if (r_rodada == r_limite)                        w_prox = FIM_GANHOU;
        else                                                  w_prox = PROX_RODADA;
      end
      PROX_JOGADA: begin
        w_addr_inc  = 1'b1;
        w_timer_clr = 1'b1;
        w_prox      = ESPERA;
      end
      PROX_RODADA: begin
        w_rodada_inc = 1'b1;
        w_addr_clr   = 1'b1;
        w_timer_clr  = 1'b1;
        w_prox       = r_desafio ? ESPERA_ESC : MOSTRA;
      end
      ESPERA_ESC: begin
        leds = r_botoes;
        if (w_jogada) begin
          if (w_multi_botoes) begin
            w_prox = FIM_PERDEU;
          end else begin
            w_prox    = ESCREVE;
            w_captura = 1'b1;
          end
        end else if (r_timer == c_TO_FIM) begin
          w_prox = FIM_TIMEOUT;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ESCREVE: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_rodada;
        w_mem_wdata = w_idx_press;
        w_timer_clr = 1'b1;
        w_prox      = MOSTRA;
      end
      default: w_prox = INICIAL;
    endcase
  end

  // Timer, sequence pointer, round counter and per-game configuration.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer   <= '0;
      r_addr    <= '0;
      r_rodada  <= '0;
      r_limite  <= '0;
      r_desafio <= 1'b0;
      r_press   <= '0;
    end else begin
      if (w_iniciar) begin
        r_timer   <= '0;
        r_addr    <= '0;
        r_rodada  <= '0;
        r_desafio <= configuracao[1];
        r_limite  <= configuracao[0] ? c_CURTO_FIM : c_PROF_FIM;
      end else begin
        if (w_timer_clr)      r_timer <= '0;
        else if (w_timer_inc) r_timer <= r_timer + c_TMR_W'(1);
        if (w_addr_clr)       r_addr <= '0;
        else if (w_addr_inc)  r_addr <= r_addr + c_ADDR_W'(1);
        if (w_rodada_inc)     r_rodada <= r_rodada + c_ADDR_W'(1);
      end
      if (w_captura) r_press <= r_botoes;
    end
  end

  // Sequence memory: synchronous write, asynchronous read, contents not reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  assign ganhou    = (r_estado == FIM_GANHOU);
  assign perdeu    = (r_estado == FIM_PERDEU);
  assign timeout   = (r_estado == FIM_TIMEOUT);
  assign pronto    = ganhou | perdeu | timeout;
  assign db_estado = r_estado;
  assign db_rodada = r_rodada;

endmodule
`default_nettype wire

// File: tb/tb_jogo_memoria_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jogo_memoria_param                                        |
// | Description : Self-checking bench for jogo_memoria_param with a polynomial |
// |               LFSR model predicting the generated sequence.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jogo_memoria_param;

  localparam int          N_BOTOES       = 4;
  localparam int          PROFUNDIDADE   = 4;
  localparam int          LED_CICLOS     = 4;
  localparam int          TIMEOUT_CICLOS = 20;
  localparam logic [15:0] SEMENTE        = 16'hACE1;

  localparam logic [4:0] S_INICIAL = 5'h00, S_PREPARA = 5'h01, S_MOSTRA = 5'h02;
  localparam logic [4:0] S_ESPERA = 5'h04, S_ESPERA_ESC = 5'h09;
  localparam logic [4:0] S_GANHOU = 5'h0A, S_PERDEU = 5'h0B, S_TIMEOUT = 5'h0C;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [1:0] configuracao = 2'b00;
  logic [3:0] botoes = 4'b0000;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu, timeout;
  logic [4:0] db_estado;
  logic [1:0] db_rodada;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int          gen_seq [PROFUNDIDADE];
  int          exp_seq [PROFUNDIDADE];
  int          rec_k = 0;
  logic [4:0]  rec_prev = 5'h1F;

  jogo_memoria_param #(
    .N_BOTOES       (N_BOTOES),
    .PROFUNDIDADE   (PROFUNDIDADE),
    .LED_CICLOS     (LED_CICLOS),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .SEMENTE        (SEMENTE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .jogar        (jogar),
    .configuracao (configuracao),
    .botoes       (botoes),
    .leds         (leds),
    .pronto       (pronto),
    .ganhou       (ganhou),
    .perdeu       (perdeu),
    .timeout      (timeout),
    .db_estado    (db_estado),
    .db_rodada    (db_rodada)
  );

  always #5 clock = ~clock;

  // Polynomial model of the free-running generator.
  always @(posedge clock or negedge reset) begin
    if (!reset) m_lfsr <= SEMENTE;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Each PREPARA clock stores the current generator value mod N_BOTOES.
  always @(negedge clock) begin
    if (reset && db_estado == S_PREPARA) begin
      if (rec_prev != S_PREPARA) rec_k = 0;
      if (rec_k < PROFUNDIDADE) gen_seq[rec_k] = int'(m_lfsr % 16'd4);
      rec_k++;
    end
    rec_prev = db_estado;
  end

  function automatic int exp_at(input int i, input bit des);
    return (des && i > 0) ? exp_seq[i] : gen_seq[i];
  endfunction

  function automatic logic [3:0] mask_of(input int idx);
    logic [3:0] m;
    m = 4'b0001 << idx;
    return m;
  endfunction

  task automatic do_reset();
    reset = 1'b0; jogar = 1'b0; botoes = 4'b0000;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (1 + $urandom_range(0, 7)) @(negedge clock);
  endtask

  task automatic pulse_jogar(input logic [1:0] cfg);
    configuracao = cfg;
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic wait_code(input logic [4:0] code, input int budget, input string nome);
    int n = 0;
    while (db_estado !== code && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (db_estado !== code) begin
      errors++;
      $display("FAIL %s: db_estado=%h required %h", nome, db_estado, code);
    end
  endtask

  task automatic check_flags(input logic [3:0] req, input string nome);
    checks++;
    if ({pronto, ganhou, perdeu, timeout} !== req) begin
      errors++;
      $display("FAIL %s: {pronto,ganhou,perdeu,timeout}=%b required %b", nome,
               {pronto, ganhou, perdeu, timeout}, req);
    end
    checks++;
    if (leds !== 4'b0000) begin
      errors++;
      $display("FAIL %s_leds: leds=%b required 0000", nome, leds);
    end
  endtask

  // Observe one playback and compare every shown led against the model.
  task automatic watch_playback(input int rodada, input bit des);
    int eps = 0, cyc = 0, n = 0;
    logic [4:0] prev = 5'h1F;
    logic [3:0] expv;
    while (db_estado !== S_ESPERA && n < 400) begin
      @(negedge clock);
      n++;
      if (db_estado == S_MOSTRA) begin
        cyc++;
        if (prev != S_MOSTRA) begin
          expv = (eps < PROFUNDIDADE) ? mask_of(exp_at(eps, des)) : 4'b0000;
          checks++;
          if (leds !== expv) begin
            errors++;
            $display("FAIL mostra_r%0d_e%0d: leds=%b required %b", rodada, eps, leds, expv);
          end
          eps++;
        end
      end
      prev = db_estado;
    end
    checks++;
    if (db_estado !== S_ESPERA) begin
      errors++;
      $display("FAIL espera_r%0d: db_estado=%h required %h", rodada, db_estado, S_ESPERA);
    end
    checks++;
    if (eps != rodada + 1) begin
      errors++;
      $display("FAIL n_leds_r%0d: shown=%0d required %0d", rodada, eps, rodada + 1);
    end
    checks++;
    if (cyc != (rodada + 1) * LED_CICLOS) begin
      errors++;
      $display("FAIL led_time_r%0d: cycles=%0d required %0d", rodada, cyc, (rodada + 1) * LED_CICLOS);
    end
    checks++;
    if (db_rodada !== 2'(rodada)) begin
      errors++;
      $display("FAIL db_rodada_r%0d: got %0d required %0d", rodada, db_rodada, rodada);
    end
  endtask

  task automatic press(input logic [3:0] mask, input logic [4:0] code, input string nome);
    wait_code(code, 100, nome);
    botoes = mask;
    @(negedge clock);
    checks++;
    if (leds !== mask) begin
      errors++;
      $display("FAIL %s_echo: leds=%b required %b", nome, leds, mask);
    end
    botoes = 4'b0000;
    @(negedge clock);
  endtask

  task automatic play_round(input int r, input bit des);
    watch_playback(r, des);
    for (int i = 0; i <= r; i++) press(mask_of(exp_at(i, des)), S_ESPERA, "replay");
  endtask

  task automatic wait_perdeu();
    int n = 0;
    while (!perdeu && n < 3) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (db_estado !== S_PERDEU) begin
      errors++;
      $display("FAIL perdeu_state: db_estado=%h required %h", db_estado, S_PERDEU);
    end
    check_flags(4'b1010, "perdeu_flags");
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (db_estado !== S_INICIAL || db_rodada !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: estado=%h rodada=%0d required 00/0", db_estado, db_rodada);
    end
    check_flags(4'b0000, "reset_flags");
    repeat (5) @(negedge clock);
    checks++;
    if (db_estado !== S_INICIAL) begin
      errors++;
      $display("FAIL idle_without_jogar: db_estado=%h required 00", db_estado);
    end
  endtask

  task automatic test_win_normal();
    do_reset();
    pulse_jogar(2'b00);
    checks++;
    if (db_estado !== S_PREPARA) begin
      errors++;
      $display("FAIL start_prepara: db_estado=%h required 01", db_estado);
    end
    for (int r = 0; r < PROFUNDIDADE; r++) play_round(r, 1'b0);
    wait_code(S_GANHOU, 10, "win_state");
    check_flags(4'b1100, "win_flags");
    repeat (5) @(negedge clock);
    check_flags(4'b1100, "win_hold");
  endtask

  task automatic test_multi_press();
    do_reset();
    pulse_jogar(2'b00);
    watch_playback(0, 1'b0);
    press(4'b1100, S_ESPERA, "multi");
    wait_perdeu();
  endtask

  task automatic test_wrong_second();
    int wrong;
    do_reset();
    pulse_jogar(2'b00);
    play_round(0, 1'b0);
    watch_playback(1, 1'b0);
    press(mask_of(exp_at(0, 1'b0)), S_ESPERA, "second_ok");
    wrong = (exp_at(1, 1'b0) + 1 + int'($urandom_range(0, 2))) % 4;
    press(mask_of(wrong), S_ESPERA, "second_wrong");
    wait_perdeu();
  endtask

  task automatic test_timeout();
    int n = 1;
    do_reset();
    pulse_jogar(2'b00);
    watch_playback(0, 1'b0);
    // jogar mid-wait must be ignored and must not disturb the timer.
    while (db_estado == S_ESPERA && n < 100) begin
      jogar = (n == 5);
      @(negedge clock);
      if (db_estado == S_ESPERA) n++;
    end
    jogar = 1'b0;
    checks++;
    if (n != TIMEOUT_CICLOS) begin
      errors++;
      $display("FAIL timeout_len: cycles=%0d required %0d", n, TIMEOUT_CICLOS);
    end
    checks++;
    if (db_estado !== S_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_state: db_estado=%h required 0C", db_estado);
    end
    check_flags(4'b1001, "timeout_flags");
    pulse_jogar(2'b00);
    checks++;
    if (db_estado !== S_PREPARA) begin
      errors++;
      $display("FAIL restart_state: db_estado=%h required 01", db_estado);
    end
    check_flags(4'b0000, "restart_flags");
  endtask

  task automatic test_desafio();
    int idx;
    do_reset();
    pulse_jogar(2'b10);
    for (int r = 0; r < PROFUNDIDADE; r++) begin
      play_round(r, 1'b1);
      if (r < PROFUNDIDADE - 1) begin
        idx = int'($urandom_range(0, 3));
        exp_seq[r + 1] = idx;
        press(mask_of(idx), S_ESPERA_ESC, "write");
      end
    end
    wait_code(S_GANHOU, 10, "desafio_win");
    check_flags(4'b1100, "desafio_flags");
  endtask

  task automatic test_reset_mid_and_curto();
    do_reset();
    pulse_jogar(2'b00);
    play_round(0, 1'b0);
    wait_code(S_MOSTRA, 100, "mid_mostra");
    checks++;
    if (db_rodada !== 2'd1) begin
      errors++;
      $display("FAIL mid_rodada: db_rodada=%0d required 1", db_rodada);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (db_estado !== S_INICIAL || db_rodada !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_state: estado=%h rodada=%0d required 00/0", db_estado, db_rodada);
    end
    check_flags(4'b0000, "async_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (1 + $urandom_range(0, 5)) @(negedge clock);
    pulse_jogar(2'b01);
    play_round(0, 1'b0);
    wait_code(S_GANHOU, 10, "curto_win");
    check_flags(4'b1100, "curto_flags");
  endtask

  initial begin
    test_reset();
    test_win_normal();
    test_multi_press();
    test_wrong_second();
    test_timeout();
    test_desafio();
    test_reset_mid_and_curto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
